disp_page_ctrl: RTL and testbench
=================================

DISP_PAGE_CTRL -- requirements
Module: disp_page_ctrl

Interface
REQ-001 SHALL have parameters:
- REF_W, default 20: refresh period of 2^REF_W cycles.
- ROT_W, default 27: auto-rotate period of 2^ROT_W cycles.
- DB_W, default 16: debounce stable time of 2^DB_W cycles.
- TMO, default 64: register-read timeout in cycles.

REQ-002 SHALL have ports (reset: asynchronous, active-high; clock: clk):
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- btn_next  in  1  raw pushbutton; page advance.
- auto_en  in  1  enable auto-rotate of pages.
- freeze  in  1  hold displayed word.
- pc  in  32  program counter.
- instr  in  32  current instruction.
- retire  in  1  one-cycle pulse per retired instruction.
- dbg_addr  in  5  register index for page 2.
- rf_req  out  1  register-read request.
- rf_addr  out  5  register-read index.
- rf_ack  in  1  one-cycle read acknowledge.
- rf_data  in  32  read data, valid when rf_ack=1.
- hex7..hex0  out  4 each  nibbles of the shown word; hex7 = bits 31:28.
- dp_out  out  8  decimal points, active-low, to the display mux.
- page  out  2  current page.

Function
REQ-003 Pages SHALL be:
- 0: pc.
- 1: instr.
- 2: register[dbg_addr].
- 3: retire count, a 32-bit counter that wraps 0xFFFFFFFF->0.

REQ-004 btn_next SHALL pass through a 2-flop synchronizer and debounce (stable 2^DB_W cycles); the rising edge of the debounced level SHALL yield a one-cycle press pulse.

REQ-005 Page advance: each press SHALL increment page modulo 4 (3->0).

REQ-006 Auto-rotate:
- When auto_en=1, the rotate counter SHALL advance page on wrap.
- A press SHALL clear the rotate counter.
- A press and a rotate wrap in the same cycle SHALL advance page by one only.

REQ-007 Update trigger SHALL be any of:
- refresh counter wrap;
- page change;
- freeze falling edge.
While freeze=1, triggers SHALL be suppressed and the shown word held; page changes still take effect on page.

REQ-008 FSM states SHALL be IDLE and RDREG.

REQ-009 IDLE behaviour on a trigger:
- Page 0, 1 or 3: the shown word SHALL be loaded from the source in the same cycle (1-cycle latency to hex outputs); remain in IDLE.
- Page 2: go to RDREG with rf_addr <= dbg_addr.

REQ-010 RDREG behaviour:
- rf_req=1, and rf_addr SHALL be held stable until exit.
- On rf_ack: shown word <= rf_data, err <= 0, go to IDLE.
- After TMO cycles without ack: shown word <= 32'hEEEE_EEEE, err <= 1, go to IDLE.

REQ-011 A page change during RDREG SHALL NOT drop rf_req.
- On completion (ack or timeout), the returned data SHALL be discarded.
- A pending trigger SHALL be serviced from IDLE the next cycle.

REQ-012 Triggers arriving in RDREG SHALL be collapsed into one pending flag.

REQ-013 dp_out SHALL be:
- ~(8'b1 << page) when err=0 (the lit point marks the page digit);
- 8'h00 when err=1.
err SHALL be cleared by any successful load.

REQ-014 retire pulses SHALL be counted every cycle regardless of state, page or freeze.

REQ-015 All outputs SHALL be registered.

Reset
REQ-016 Reset SHALL set:
- state IDLE, page 0, shown word 0 (all hex 0), err 0;
- dp_out 8'hFE, rf_req 0, rf_addr 0;
- retire count 0, all internal counters 0, pending flag 0.

REQ-017 Reset during RDREG SHALL drop rf_req immediately; any later rf_ack in IDLE SHALL be ignored.

Structure
REQ-018 Package disp_pkg SHALL hold:
- page_t enum (PG_PC, PG_INSTR, PG_REG, PG_RETIRE);
- state_t enum;
- ERR_WORD = 32'hEEEE_EEEE.

REQ-019 Sub-module debounce SHALL provide the synchronizer, debounce and edge pulse (param DB_W); it SHALL be instantiated once.

Verification (REF_W=4, ROT_W=6, DB_W=2, TMO=8)
REQ-020 After reset, set pc=32'h0040_0010 and wait 16 cycles -> hex7..hex0 = 0,0,4,0,0,0,1,0; dp_out = 8'hFE.

REQ-021 Two clean presses with dbg_addr=5 -> page=2; rf_req rises with rf_addr=5. Ack after 3 cycles with 32'h1234_ABCD -> shown word 1234ABCD, dp_out = 8'hFB, rf_req low.

REQ-022 Page 2 with no ack -> after 8 cycles, shown word EEEEEEEE, dp_out = 8'h00. Next ack of 32'h1 -> dp_out = 8'hFB.

REQ-023 Press while rf_req is high, then ack 32'hFFFF_FFFF -> value not displayed; page=3; retire count shown next cycle.

REQ-024 auto_en=1 with a press coincident with the rotate wrap -> page advances by exactly 1. Page 3->0 wraps.

REQ-025 Behaviour under load and reset:
- 0xFFFFFFFF retire pulses -> page 3 shows FFFFFFFF; one more pulse -> 00000000.
- freeze=1 holds the word while pc changes.
- Reset mid-RDREG -> rf_req=0 next cycle.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the display page controller.
package disp_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        PG_PC     = 2'd0,
        PG_INSTR  = 2'd1,
        PG_REG    = 2'd2,
        PG_RETIRE = 2'd3
    } page_t;

    typedef enum logic {
        IDLE  = 1'b0,
        RDREG = 1'b1
    } state_t;

    localparam logic [WORD_W-1:0] ERR_WORD = 32'hEEEE_EEEE;

    // Active-low decimal points: one lit point marks the page digit, all lit on error.
    function automatic logic [7:0] dp_pattern(input page_t pg, input logic err);
        return err ? 8'h00 : ~(8'b1 << pg);
    endfunction

endpackage

// File: rtl/debounce.sv
// Pushbutton synchronizer, debouncer and rising-edge press pulse.
module debounce #(
    parameter int unsigned DB_W = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam logic [DB_W-1:0] CNT_MAX = '1;

    logic            sync1_q;
    logic            sync2_q;
    logic            level_q;
    logic [DB_W-1:0] cnt_q;

    // Level only follows the synchronized input after it has differed for 2^DB_W cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press   <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            press   <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
                press   <= sync2_q;
            end else begin
                cnt_q <= cnt_q + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/disp_page_ctrl.sv
// Debug display controller: selects a page, refreshes the shown word, fetches registers.
module disp_page_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned REF_W = 20,
    parameter int unsigned ROT_W = 27,
    parameter int unsigned DB_W  = 16,
    parameter int unsigned TMO   = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_next,
    input  logic        auto_en,
    input  logic        freeze,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        retire,
    input  logic [4:0]  dbg_addr,
    output logic        rf_req,
    output logic [4:0]  rf_addr,
    input  logic        rf_ack,
    input  logic [31:0] rf_data,
    output logic [3:0]  hex7,
    output logic [3:0]  hex6,
    output logic [3:0]  hex5,
    output logic [3:0]  hex4,
    output logic [3:0]  hex3,
    output logic [3:0]  hex2,
    output logic [3:0]  hex1,
    output logic [3:0]  hex0,
    output logic [7:0]  dp_out,
    output logic [1:0]  page
);

    localparam int unsigned    TMO_W    = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);

    state_t            state_q,   state_d;
    page_t             page_q,    page_d;
    logic [REF_W-1:0]  ref_q,     ref_d;
    logic [ROT_W-1:0]  rot_q,     rot_d;
    logic [TMO_W-1:0]  tmo_q,     tmo_d;
    logic [WORD_W-1:0] word_q,    word_d;
    logic [WORD_W-1:0] retire_cnt_q, retire_cnt_d;
    logic              err_q,     err_d;
    logic [7:0]        dp_q,      dp_d;
    logic              rf_req_q,  rf_req_d;
    logic [4:0]        rf_addr_q, rf_addr_d;
    logic              pend_q,    pend_d;
    logic              stale_q,   stale_d;
    logic              pg_chg_q,  pg_chg_d;
    logic              frz_q;

    logic              press;
    logic              ref_wrap;
    logic              rot_wrap;
    logic              advance;
    logic              frz_fall;
    logic              trig;
    logic              discard;
    logic [WORD_W-1:0] src_word;

    // Debounced page-advance button.
    debounce #(.DB_W(DB_W)) u_debounce (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_next),
        .press (press)
    );

    assign ref_wrap = (ref_q == '1);
    assign rot_wrap = auto_en && (rot_q == '1);
    assign advance  = press || rot_wrap;
    assign frz_fall = frz_q && !freeze;
    assign trig     = (ref_wrap || pg_chg_q || frz_fall) && !freeze;
    // A read that straddles a page change or a freeze no longer belongs on the display.
    assign discard  = stale_q || pg_chg_q || freeze;

    // Source word for the directly readable pages.
    always_comb begin
        src_word = retire_cnt_q;
        case (page_q)
            PG_PC:    src_word = pc;
            PG_INSTR: src_word = instr;
            default:  src_word = retire_cnt_q;
        endcase
    end

    // Next-state and datapath update.
    always_comb begin
        state_d      = state_q;
        page_d       = page_q;
        ref_d        = ref_q + REF_W'(1);
        rot_d        = rot_q;
        tmo_d        = tmo_q;
        word_d       = word_q;
        retire_cnt_d = retire_cnt_q + WORD_W'(retire);
        err_d        = err_q;
        rf_addr_d    = rf_addr_q;
        pend_d       = pend_q;
        stale_d      = stale_q;
        pg_chg_d     = advance;

        if (press) begin
            rot_d = '0;
        end else if (auto_en) begin
            rot_d = rot_q + ROT_W'(1);
        end

        if (advance) begin
            page_d = page_t'(page_q + 2'd1);
        end

        case (state_q)
            IDLE: begin
                if ((trig || pend_q) && !freeze) begin
                    pend_d = 1'b0;
                    if (page_q == PG_REG) begin
                        state_d   = RDREG;
                        rf_addr_d = dbg_addr;
                        tmo_d     = '0;
                        stale_d   = 1'b0;
                    end else begin
                        word_d = src_word;
                        err_d  = 1'b0;
                    end
                end
            end
            default: begin
                pend_d = pend_q || trig;
                if (pg_chg_q) begin
                    stale_d = 1'b1;
                end
                if (rf_ack) begin
                    state_d = IDLE;
                    if (!discard) begin
                        word_d = rf_data;
                        err_d  = 1'b0;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    if (!discard) begin
                        word_d = ERR_WORD;
                        err_d  = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
        endcase

        rf_req_d = (state_d == RDREG);
        dp_d     = dp_pattern(page_d, err_d);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            page_q       <= PG_PC;
            ref_q        <= '0;
            rot_q        <= '0;
            tmo_q        <= '0;
            word_q       <= '0;
            retire_cnt_q <= '0;
            err_q        <= 1'b0;
            dp_q         <= 8'hFE;
            rf_req_q     <= 1'b0;
            rf_addr_q    <= '0;
            pend_q       <= 1'b0;
            stale_q      <= 1'b0;
            pg_chg_q     <= 1'b0;
            frz_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            page_q       <= page_d;
            ref_q        <= ref_d;
            rot_q        <= rot_d;
            tmo_q        <= tmo_d;
            word_q       <= word_d;
            retire_cnt_q <= retire_cnt_d;
            err_q        <= err_d;
            dp_q         <= dp_d;
            rf_req_q     <= rf_req_d;
            rf_addr_q    <= rf_addr_d;
            pend_q       <= pend_d;
            stale_q      <= stale_d;
            pg_chg_q     <= pg_chg_d;
            frz_q        <= freeze;
        end
    end

    assign rf_req  = rf_req_q;
    assign rf_addr = rf_addr_q;
    assign dp_out  = dp_q;
    assign page    = page_q;
    assign hex7    = word_q[31:28];
    assign hex6    = word_q[27:24];
    assign hex5    = word_q[23:20];
    assign hex4    = word_q[19:16];
    assign hex3    = word_q[15:12];
    assign hex2    = word_q[11:8];
    assign hex1    = word_q[7:4];
    assign hex0    = word_q[3:0];

endmodule

// File: tb/tb_disp_page_ctrl.sv
// Scenario bench for disp_page_ctrl with a word scoreboard.
module tb_disp_page_ctrl;

    localparam int unsigned REF_W = 4;
    localparam int unsigned ROT_W = 6;
    localparam int unsigned DB_W  = 2;
    localparam int unsigned TMO   = 8;

    logic        clk;
    logic        reset;
    logic        btn_next;
    logic        auto_en;
    logic        freeze;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        retire;
    logic [4:0]  dbg_addr;
    logic        rf_req;
    logic [4:0]  rf_addr;
    logic        rf_ack;
    logic [31:0] rf_data;
    logic [3:0]  hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0;
    logic [7:0]  dp_out;
    logic [1:0]  page;
    logic [31:0] shown;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ret_model;

    assign shown = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

    disp_page_ctrl #(.REF_W(REF_W), .ROT_W(ROT_W), .DB_W(DB_W), .TMO(TMO)) dut (
        .clk(clk), .reset(reset), .btn_next(btn_next), .auto_en(auto_en),
        .freeze(freeze), .pc(pc), .instr(instr), .retire(retire),
        .dbg_addr(dbg_addr), .rf_req(rf_req), .rf_addr(rf_addr),
        .rf_ack(rf_ack), .rf_data(rf_data),
        .hex7(hex7), .hex6(hex6), .hex5(hex5), .hex4(hex4),
        .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .dp_out(dp_out), .page(page)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_retire(input int n);
        for (int i = 0; i < n; i++) begin
            retire = 1'b1;
            step();
            retire = 1'b0;
            ret_model = ret_model + 32'd1;
        end
    endtask

    task automatic press_and_wait(input logic [1:0] exp_pg);
        int n;
        n = 0;
        btn_next = 1'b1;
        while (page !== exp_pg && n < 20) begin
            step();
            n++;
        end
        btn_next = 1'b0;
        total++;
        if (page !== exp_pg) begin
            bad++;
            $display("FAIL press_page: page=%0d want %0d", page, exp_pg);
        end
    endtask

    task automatic wait_req_rise(output bit ok);
        int n;
        n = 0;
        while (rf_req === 1'b1 && n < 20) begin
            step();
            n++;
        end
        n = 0;
        while (rf_req !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        ok = (rf_req === 1'b1);
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL req_wait: rf_req=%b want 1", rf_req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; btn_next = 1'b0; auto_en = 1'b0; freeze = 1'b0;
        pc = 32'h0; instr = 32'h8C08_0004; retire = 1'b0; dbg_addr = 5'd0;
        rf_ack = 1'b0; rf_data = 32'h0; ret_model = 32'h0;
        repeat (3) step();
        total++; if (page !== 2'd0)     begin bad++; $display("FAIL rst_page: got %0d want 0", page); end
        total++; if (shown !== 32'h0)   begin bad++; $display("FAIL rst_word: got %h want 00000000", shown); end
        total++; if (dp_out !== 8'hFE)  begin bad++; $display("FAIL rst_dp: got %h want fe", dp_out); end
        total++; if (rf_req !== 1'b0)   begin bad++; $display("FAIL rst_req: got %b want 0", rf_req); end
        total++; if (rf_addr !== 5'd0)  begin bad++; $display("FAIL rst_addr: got %0d want 0", rf_addr); end
        reset = 1'b0;
    endtask

    task automatic test_pc_page();
        logic [31:0] e;
        pc = 32'h0040_0010;
        exp_q.push_back(pc);
        repeat (18) step();
        e = exp_q.pop_front();
        total++; if (shown !== e)      begin bad++; $display("FAIL pc_word: got %h want %h", shown, e); end
        total++; if (dp_out !== 8'hFE) begin bad++; $display("FAIL pc_dp: got %h want fe", dp_out); end
    endtask

    task automatic test_reg_read();
        bit ok;
        logic [31:0] e;
        dbg_addr = 5'd5;
        press_and_wait(2'd1);
        exp_q.push_back(instr);
        step();
        e = exp_q.pop_front();
        total++; if (shown !== e) begin bad++; $display("FAIL instr_word: got %h want %h", shown, e); end
        repeat (10) step();
        press_and_wait(2'd2);
        wait_req_rise(ok);
        if (ok) begin
            total++; if (rf_addr !== 5'd5) begin bad++; $display("FAIL rd_addr: got %0d want 5", rf_addr); end
            repeat (2) step();
            rf_ack = 1'b1; rf_data = 32'h1234_ABCD;
            exp_q.push_back(32'h1234_ABCD);
            step();
            rf_ack = 1'b0;
            e = exp_q.pop_front();
            total++; if (shown !== e)      begin bad++; $display("FAIL rd_word: got %h want %h", shown, e); end
            total++; if (dp_out !== 8'hFB) begin bad++; $display("FAIL rd_dp: got %h want fb", dp_out); end
            total++; if (rf_req !== 1'b0)  begin bad++; $display("FAIL rd_req_low: got %b want 0", rf_req); end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        logic [31:0] e;
        dbg_addr = 5'd9;
        wait_req_rise(ok);
        if (ok) begin
            total++; if (rf_addr !== 5'd9) begin bad++; $display("FAIL tmo_addr: got %0d want 9", rf_addr); end
            exp_q.push_back(32'hEEEE_EEEE);
            n = 0;
            while (rf_req === 1'b1 && n < 20) begin
                n++;
                step();
            end
            total++; if (n != TMO) begin bad++; $display("FAIL tmo_len: got %0d want %0d", n, TMO); end
            e = exp_q.pop_front();
            total++; if (shown !== e)      begin bad++; $display("FAIL tmo_word: got %h want %h", shown, e); end
            total++; if (dp_out !== 8'h00) begin bad++; $display("FAIL tmo_dp: got %h want 00", dp_out); end
        end
        wait_req_rise(ok);
        if (ok) begin
            step();
            rf_ack = 1'b1; rf_data = 32'h0000_0001;
            exp_q.push_back(32'h0000_0001);
            step();
            rf_ack = 1'b0;
            e = exp_q.pop_front();
            total++; if (shown !== e)      begin bad++; $display("FAIL recov_word: got %h want %h", shown, e); end
            total++; if (dp_out !== 8'hFB) begin bad++; $display("FAIL recov_dp: got %h want fb", dp_out); end
        end
    endtask

    task automatic test_press_during_read();
        bit ok;
        int n;
        logic [31:0] e;
        pulse_retire(5);
        wait_req_rise(ok);
        if (ok) begin
            btn_next = 1'b1;
            n = 0;
            while (page !== 2'd3 && rf_req === 1'b1 && n < 12) begin
                step();
                n++;
            end
            total++;
            if (!(page === 2'd3 && rf_req === 1'b1)) begin
                bad++;
                $display("FAIL press_in_read: page=%0d rf_req=%b want page=3 rf_req=1", page, rf_req);
            end
            rf_ack = 1'b1; rf_data = 32'hFFFF_FFFF;
            step();
            rf_ack = 1'b0;
            btn_next = 1'b0;
            total++; if (shown === 32'hFFFF_FFFF) begin bad++; $display("FAIL stale_drop: got %h want not ffffffff", shown); end
            total++; if (rf_req !== 1'b0)        begin bad++; $display("FAIL stale_req: got %b want 0", rf_req); end
            exp_q.push_back(ret_model);
            step();
            e = exp_q.pop_front();
            total++; if (shown !== e) begin bad++; $display("FAIL pend_retire: got %h want %h", shown, e); end
        end
        btn_next = 1'b0;
    endtask

    task automatic test_page_wrap();
        logic [31:0] e;
        repeat (10) step();
        press_and_wait(2'd0);
        exp_q.push_back(pc);
        step();
        e = exp_q.pop_front();
        total++; if (shown !== e)      begin bad++; $display("FAIL wrap_word: got %h want %h", shown, e); end
        total++; if (dp_out !== 8'hFE) begin bad++; $display("FAIL wrap_dp: got %h want fe", dp_out); end
    endtask

    task automatic test_freeze();
        logic [31:0] e;
        repeat (20) step();
        exp_q.push_back(32'h0040_0010);
        e = exp_q.pop_front();
        total++; if (shown !== e) begin bad++; $display("FAIL frz_pre: got %h want %h", shown, e); end
        freeze = 1'b1;
        step();
        pc = 32'hDEAD_BEEF;
        exp_q.push_back(32'h0040_0010);
        repeat (40) step();
        e = exp_q.pop_front();
        total++; if (shown !== e) begin bad++; $display("FAIL frz_hold: got %h want %h", shown, e); end
        freeze = 1'b0;
        exp_q.push_back(32'hDEAD_BEEF);
        repeat (2) step();
        e = exp_q.pop_front();
        total++; if (shown !== e) begin bad++; $display("FAIL frz_release: got %h want %h", shown, e); end
    endtask

    task automatic test_auto_rotate();
        int n;
        repeat (10) step();
        auto_en = 1'b1;
        n = 0;
        while (page === 2'd0 && n < 100) begin
            step();
            n++;
        end
        total++; if (page !== 2'd1) begin bad++; $display("FAIL rot_first: got %0d want 1", page); end
        repeat (57) step();
        btn_next = 1'b1;
        repeat (6) step();
        total++; if (page !== 2'd1) begin bad++; $display("FAIL rot_before: got %0d want 1", page); end
        step();
        total++; if (page !== 2'd2) begin bad++; $display("FAIL rot_coincide: got %0d want 2", page); end
        btn_next = 1'b0;
        repeat (10) step();
        total++; if (page !== 2'd2) begin bad++; $display("FAIL rot_single: got %0d want 2", page); end
        btn_next = 1'b1;
        n = 0;
        while (page !== 2'd3 && n < 20) begin
            step();
            n++;
        end
        btn_next = 1'b0;
        total++; if (page !== 2'd3) begin bad++; $display("FAIL rot_press: got %0d want 3", page); end
        repeat (63) step();
        total++; if (page !== 2'd3) begin bad++; $display("FAIL rot_cleared: got %0d want 3", page); end
        step();
        total++; if (page !== 2'd0) begin bad++; $display("FAIL rot_wrap30: got %0d want 0", page); end
        auto_en = 1'b0;
    endtask

    task automatic test_retire_wrap();
        int n;
        logic [31:0] e;
        for (int p = 1; p <= 3; p++) begin
            repeat (10) step();
            press_and_wait(2'(p));
        end
        exp_q.push_back(ret_model);
        e = exp_q.pop_front();
        n = 0;
        while (shown !== e && n < 20) begin step(); n++; end
        total++; if (shown !== e) begin bad++; $display("FAIL ret_small: got %h want %h", shown, e); end
        force dut.retire_cnt_q = 32'hFFFF_FFFE;
        step();
        release dut.retire_cnt_q;
        ret_model = 32'hFFFF_FFFE;
        pulse_retire(1);
        exp_q.push_back(ret_model);
        e = exp_q.pop_front();
        n = 0;
        while (shown !== e && n < 20) begin step(); n++; end
        total++; if (shown !== e) begin bad++; $display("FAIL ret_max: got %h want %h", shown, e); end
        pulse_retire(1);
        exp_q.push_back(ret_model);
        e = exp_q.pop_front();
        n = 0;
        while (shown !== e && n < 20) begin step(); n++; end
        total++; if (shown !== e) begin bad++; $display("FAIL ret_wrap: got %h want %h", shown, e); end
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        logic [31:0] e;
        for (int p = 0; p <= 2; p++) begin
            repeat (10) step();
            press_and_wait(2'(p));
        end
        wait_req_rise(ok);
        if (ok) begin
            step();
            reset = 1'b1;
            #1;
            total++; if (rf_req !== 1'b0)  begin bad++; $display("FAIL rstrd_req: got %b want 0", rf_req); end
            total++; if (rf_addr !== 5'd0) begin bad++; $display("FAIL rstrd_addr: got %0d want 0", rf_addr); end
            step();
            reset = 1'b0;
            step();
            rf_ack = 1'b1; rf_data = 32'h1234_5678;
            exp_q.push_back(32'h0);
            step();
            rf_ack = 1'b0;
            e = exp_q.pop_front();
            total++; if (shown !== e)      begin bad++; $display("FAIL late_ack_word: got %h want %h", shown, e); end
            total++; if (dp_out !== 8'hFE) begin bad++; $display("FAIL late_ack_dp: got %h want fe", dp_out); end
            total++; if (rf_req !== 1'b0)  begin bad++; $display("FAIL late_ack_req: got %b want 0", rf_req); end
        end
    endtask

    initial begin
        test_reset();
        test_pc_page();
        test_reg_read();
        test_timeout();
        test_press_during_read();
        test_page_wrap();
        test_freeze();
        test_auto_rotate();
        test_retire_wrap();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
